seq_mul_acc: RTL and testbench

SEQ_MUL_ACC -- requirements
Module: seq_mul_acc

---
 rtl/seq_mul_pkg.sv | 15 +
 rtl/mul_digit.sv | 12 +
 rtl/seq_mul_acc.sv | 159 +++++++++++++++
 tb/tb_seq_mul_acc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the digit-serial multiply-accumulate block:
// FSM state encoding and the digit-count helper.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_k(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/mul_digit.sv
// Combinational DIGIT x DIGIT unsigned multiplier producing one partial product.
module mul_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0]   a,
    input  logic [DIGIT-1:0]   b,
    output logic [2*DIGIT-1:0] p
);

    assign p = (2*DIGIT)'(a) * (2*DIGIT)'(b);

endmodule

// File: rtl/seq_mul_acc.sv
// Digit-serial unsigned multiply-accumulate: one DIGIT x DIGIT partial product
// per cycle for K*K cycles, added into a 2*WIDTH accumulator with carry-out tracking.
module seq_mul_acc
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               acc_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               ovf
);

    localparam int K     = calc_k(WIDTH, DIGIT);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [IDX_W-1:0]    r_i;
    logic [IDX_W-1:0]    r_j;
    logic [PW-1:0]       r_out;
    logic                r_ovf;
    logic                r_busy;
    logic                r_done;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_accept;
    logic                w_last;
    logic [DIGIT-1:0]    w_a_dig;
    logic [DIGIT-1:0]    w_b_dig;
    logic [2*DIGIT-1:0]  w_prod;
    logic [31:0]         w_shamt;
    logic [PW-1:0]       w_term;
    logic [PW:0]         w_sum;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_i == LAST) && (r_j == LAST);

    // j walks the multiplicand digits, i the multiplier digits
    assign w_a_dig  = r_a[int'(r_j) * DIGIT +: DIGIT];
    assign w_b_dig  = r_b[int'(r_i) * DIGIT +: DIGIT];

    mul_digit #(
        .DIGIT (DIGIT)
    ) u_mul_digit (
        .a (w_a_dig),
        .b (w_b_dig),
        .p (w_prod)
    );

    // Sum is one bit wider than the accumulator so the carry-out is visible
    assign w_shamt = 32'(DIGIT) * (32'(r_i) + 32'(r_j));
    assign w_term  = PW'(w_prod) << w_shamt;
    assign w_sum   = {1'b0, r_out} + {1'b0, w_term};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
                else       w_next = IDLE;
            end
            RUN: begin
                if (w_last) w_next = DONE;
                else        w_next = RUN;
            end
            DONE: begin
                if (start) w_next = RUN;
                else       w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Status decode from the upcoming state so busy/done can be registered
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_next)
            RUN:     w_busy_nxt = 1'b1;
            DONE:    w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand latch, digit indices and accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= {WIDTH{1'b0}};
            r_b   <= {WIDTH{1'b0}};
            r_i   <= {IDX_W{1'b0}};
            r_j   <= {IDX_W{1'b0}};
            r_out <= {PW{1'b0}};
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_i   <= {IDX_W{1'b0}};
            r_j   <= {IDX_W{1'b0}};
            r_ovf <= 1'b0;
            if (!acc_mode) begin
                r_out <= {PW{1'b0}};
            end
        end else if (r_state == RUN) begin
            r_out <= w_sum[PW-1:0];
            r_ovf <= r_ovf | w_sum[PW];
            if (w_last) begin
                r_i <= {IDX_W{1'b0}};
                r_j <= {IDX_W{1'b0}};
            end else if (r_j == LAST) begin
                r_j <= {IDX_W{1'b0}};
                r_i <= r_i + IDX_W'(1);
            end else begin
                r_j <= r_j + IDX_W'(1);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_mul_acc.sv
// Directed self-checking bench for seq_mul_acc (WIDTH=8, DIGIT=2, K=4) with a
// reference-model sweep of random operand pairs.
module tb_seq_mul_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        acc_mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_cnt;

    logic [15:0] ref_out;
    logic        ref_ovf;
    logic [16:0] ref_sum;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rm;

    always #5 clk = ~clk;

    seq_mul_acc #(
        .WIDTH (8),
        .DIGIT (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .acc_mode (acc_mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic tm);
        a        = ta;
        b        = tb_v;
        acc_mode = tm;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Waits (bounded) for done, checking the run length and busy cycle count.
    task automatic wait_done(input string tag);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            busy_cnt += int'(busy);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd16);
        chk({tag, "_busycycles"}, 32'(busy_cnt), 32'd16);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        acc_mode = 1'b0;
        a        = 8'd0;
        b        = 8'd0;
        #1;
        chk("reset_out",  32'(out),  32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ovf",  32'(ovf),  32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 255*255 from a cleared accumulator
        launch(8'd255, 8'd255, 1'b0);
        chk("ff_busy_first", 32'(busy), 32'd1);
        wait_done("ff");
        chk("ff_done", 32'(done), 32'd1);
        chk("ff_busy_at_done", 32'(busy), 32'd0);
        chk("ff_out", 32'(out), 32'h0000FE01);
        chk("ff_ovf", 32'(ovf), 32'd0);
        tick();

        // Accumulate another 255*255: 0xFE01+0xFE01 = 0x1FC02
        launch(8'd255, 8'd255, 1'b1);
        wait_done("acc");
        chk("acc_out", 32'(out), 32'h0000FC02);
        chk("acc_ovf", 32'(ovf), 32'd1);
        tick();
        chk("hold_done", 32'(done), 32'd0);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_out",  32'(out),  32'h0000FC02);
        chk("hold_ovf",  32'(ovf),  32'd1);

        // Start held through RUN with a changing: only the DONE-cycle start is taken
        a        = 8'd13;
        b        = 8'd11;
        acc_mode = 1'b0;
        start    = 1'b1;
        tick();
        a        = 8'd7;
        wait_done("held");
        chk("held_out", 32'(out), 32'd143);
        chk("held_ovf_cleared", 32'(ovf), 32'd0);
        tick();
        start = 1'b0;
        chk("held_done_single", 32'(done), 32'd0);
        chk("held_restart_busy", 32'(busy), 32'd1);
        wait_done("held2");
        chk("held2_out", 32'(out), 32'd77);

        // Back-to-back start taken in DONE
        launch(8'd3, 8'd5, 1'b0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done", 32'(done), 32'd0);
        wait_done("b2b");
        chk("b2b_out", 32'(out), 32'd15);
        tick();

        // Reset in RUN cycle 7 aborts the operation
        launch(8'd9, 8'd9, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_out",  32'(out),  32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ovf",  32'(ovf),  32'd0);
        busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            busy_cnt += int'(done) + int'(busy);
        end
        chk("abort_no_done", 32'(busy_cnt), 32'd0);
        rst = 1'b1;
        launch(8'd2, 8'd0, 1'b0);
        chk("post_rst_busy", 32'(busy), 32'd1);
        wait_done("zero");
        chk("zero_out", 32'(out), 32'd0);
        chk("zero_ovf", 32'(ovf), 32'd0);

        // Random sweep against a reference accumulator
        ref_out = 16'd0;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            if (rm) ref_sum = {1'b0, ref_out} + 17'(ra) * 17'(rb);
            else    ref_sum = 17'(ra) * 17'(rb);
            ref_out = ref_sum[15:0];
            ref_ovf = ref_sum[16];
            launch(ra, rb, rm);
            wait_done("rnd");
            chk("rnd_out", 32'(out), 32'(ref_out));
            chk("rnd_ovf", 32'(ovf), 32'(ref_ovf));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
